apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Per-core APB master front end. It converts a core's single-outstanding load/store request (req/ack) into a compliant two-phase APB transfer (SETUP then ACCESS). One instance sits between each core's memory stage and one master slot of the APB interconnect's `S_*` port bundle. It registers address, write data and read data, so the core sees a clean one-cycle `ack`.

## Interface
- `BUS_WIDTH`, 16, width of address and data.
- `TIMEOUT`, 255, maximum ACCESS cycles before abort; only used with the timeout feature.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. One clock; asserting `reset` low clears all state immediately.
- `req` in 1: core request; held high until `ack`.
- `we` in 1: 1 = store, 0 = load; sampled with `req`.
- `addr` in BUS_WIDTH: byte/word address; sampled with `req`.
- `wdata` in BUS_WIDTH: store data; sampled with `req`.
- `rdata` out BUS_WIDTH: load data; valid in the `ack` cycle and held until the next `ack`.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: timeout abort flag; valid with `ack`.
- `busy` out 1: high in SETUP and ACCESS.
- `M_PADDR` out BUS_WIDTH, `M_PWRITE` out 1, `M_PSELx` out 1, `M_PENABLE` out 1, `M_PWDATA` out BUS_WIDTH: APB request to the interconnect. All are driven from registers.
- `M_PRDATA` in BUS_WIDTH, `M_PREADY` in 1: APB response from the interconnect.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- **IDLE:** `M_PSELx` = 0 and `M_PENABLE` = 0.
  - If `req` = 1 and `ack` = 0, latch `addr`, `we` and `wdata` into the `M_*` registers, then go to SETUP.
  - `req` is ignored in the cycle `ack` is high, which prevents re-triggering on a held request.
- **SETUP:** `M_PSELx` = 1, `M_PENABLE` = 0. Always go to ACCESS next cycle.
- **ACCESS:** `M_PSELx` = 1, `M_PENABLE` = 1.
  - On `M_PREADY` = 1: capture `M_PRDATA` into `rdata` on loads only, since `rdata` is unchanged on stores. Then go to DONE.
  - On `M_PREADY` = 0: stay in ACCESS. Address, data and control are held stable.
- **DONE:** `ack` = 1 for exactly this cycle, `M_PSELx` = 0 and `M_PENABLE` = 0. Go to IDLE.
- `M_PSELx` drops between transfers. The interconnect's arbiter uses this to rotate to the next master.
- `M_PADDR`, `M_PWRITE` and `M_PWDATA` retain their last values in IDLE and DONE; they are not zeroed.
- Changes on `addr`, `we` or `wdata` after acceptance have no effect on the transfer in flight.

## Timing
- Reset values: `M_PSELx` = 0, `M_PENABLE` = 0, `M_PWRITE` = 0, `M_PADDR` = 0, `M_PWDATA` = 0, `rdata` = 0, `ack` = 0, `err` = 0, `busy` = 0, state = IDLE.
- Cycle-level sequence:
  - Cycle 0: `req` sampled.
  - Cycle 1: SETUP.
  - Cycle 2: first ACCESS.
  - Zero-wait slave (PREADY high in cycle 2): `ack` in cycle 3.
  - Each wait state adds 1 cycle.
- Minimum request-to-request period is 4 cycles: `req` may be re-raised in the cycle after `ack`.
- Reset mid-transfer: outputs return to reset values asynchronously, with no `ack`. The slave sees PSEL drop; this is permitted only under global reset.
- If `M_PREADY` is high outside ACCESS, it is ignored.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - An 8+ bit counter (width `clog2(TIMEOUT+1)`) clears on entry to ACCESS and increments each ACCESS cycle with `M_PREADY` = 0.
  - When the count reaches `TIMEOUT` with `M_PREADY` still 0, go to DONE with `err` = 1 and `rdata` = 0.
  - `err` returns to 0 on the next accepted request.
  - `M_PREADY` arriving in the same cycle as expiry wins: normal completion, `err` = 0.
- Not defined: no counter; ACCESS waits indefinitely; `err` is tied to 0.

## Test plan
- **Zero-wait load:** `req`=1, `we`=0, `addr`=0x0010, and the slave returns `M_PRDATA`=0xBEEF with PREADY high on the first ACCESS cycle. Required: SETUP in cycle 1, ACCESS in cycle 2, `ack` in cycle 3 with `rdata`=0xBEEF and `err`=0, and `M_PSELx` low in cycle 3.
- **Store with 3 wait states:** `we`=1, `addr`=0x0020, `wdata`=0x1234, and PREADY rises in the 4th ACCESS cycle. Required: PADDR, PWDATA and PWRITE stay stable throughout, `ack` in cycle 6, and `rdata` keeps its previous value.
- **Request hygiene:** `req` is held high through `ack`, and `addr` is changed during ACCESS. Required: exactly one transfer at the original address, and no new SETUP in the `ack` cycle. A new transfer starts only after `req` is re-raised.
- **Back-to-back:** two loads issued as fast as allowed. Required: `M_PSELx` is low for at least one cycle between them, and the second `ack` comes 4 cycles after the first.
- **Async reset mid-ACCESS:** `reset` is pulled low with PREADY held low. Required: PSEL, PENABLE and `busy` go to 0 immediately, there is no `ack`, and after release a new `req` completes normally.
- **Timeout (`APB_MASTER_TIMEOUT_EN`, `TIMEOUT`=4):** PREADY stays low. Required: `ack` with `err`=1 and `rdata`=0 after 4 ACCESS cycles, and PSEL drops. A repeat with PREADY high exactly at expiry gives `err`=0 and the slave data.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Per-core APB master front end: turns a single-outstanding req/ack load/store into a SETUP/ACCESS APB transfer.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int BUS_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [BUS_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0] wdata,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic                 ack,
    output logic                 err,
    output logic                 busy,
    output logic [BUS_WIDTH-1:0] M_PADDR,
    output logic                 M_PWRITE,
    output logic                 M_PSELx,
    output logic                 M_PENABLE,
    output logic [BUS_WIDTH-1:0] M_PWDATA,
    input  logic [BUS_WIDTH-1:0] M_PRDATA,
    input  logic                 M_PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [BUS_WIDTH-1:0]   paddr_r;
    logic [BUS_WIDTH-1:0]   pwdata_r;
    logic [BUS_WIDTH-1:0]   rdata_r;
    logic                   pwrite_r;
    logic                   psel_r;
    logic                   penable_r;
    logic                   ack_r;
    logic                   err_r;
    logic                   busy_r;
    logic                   accept_s;
    logic                   expire_s;

    // ack is only ever high in DONE, but the guard keeps a held req from re-triggering.
    assign accept_s = (state_r == IDLE) && req && !ack_r;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_r;

    // Expiry is the TIMEOUT-th ACCESS cycle without PREADY; PREADY in that cycle still wins.
    assign expire_s = (state_r == ACCESS) && !M_PREADY &&
                      (wait_cnt_r == CNT_W'(TIMEOUT - 1));

    // Wait counter: cleared on entry to ACCESS, counts stalled ACCESS cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r != ACCESS) && (state_nxt_s == ACCESS)) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ACCESS) && !M_PREADY) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = ACCESS;
            end
            ACCESS: begin
                if (M_PREADY || expire_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered bus/core outputs, decoded one cycle ahead from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            busy_r    <= 1'b0;
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {BUS_WIDTH{1'b0}};
            pwdata_r  <= {BUS_WIDTH{1'b0}};
            rdata_r   <= {BUS_WIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            psel_r    <= (state_nxt_s == SETUP) || (state_nxt_s == ACCESS);
            penable_r <= (state_nxt_s == ACCESS);
            busy_r    <= (state_nxt_s == SETUP) || (state_nxt_s == ACCESS);
            ack_r     <= (state_nxt_s == DONE);
            if (accept_s) begin
                paddr_r  <= addr;
                pwdata_r <= wdata;
                pwrite_r <= we;
                err_r    <= 1'b0;
            end
            // Stores leave rdata untouched; a timeout forces it to zero.
            if ((state_r == ACCESS) && M_PREADY) begin
                if (!pwrite_r) begin
                    rdata_r <= M_PRDATA;
                end
            end else if (expire_s) begin
                rdata_r <= {BUS_WIDTH{1'b0}};
                err_r   <= 1'b1;
            end
        end
    end

    assign M_PADDR   = paddr_r;
    assign M_PWDATA  = pwdata_r;
    assign M_PWRITE  = pwrite_r;
    assign M_PSELx   = psel_r;
    assign M_PENABLE = penable_r;
    assign rdata     = rdata_r;
    assign ack       = ack_r;
    assign err       = err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; timeout cases run when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;
    logic [15:0] m_paddr;
    logic        m_pwrite;
    logic        m_psel;
    logic        m_penable;
    logic [15:0] m_pwdata;
    logic [15:0] m_prdata = 16'h0000;
    logic        m_pready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    apb_master_bridge #(.BUS_WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy),
        .M_PADDR(m_paddr), .M_PWRITE(m_pwrite), .M_PSELx(m_psel), .M_PENABLE(m_penable),
        .M_PWDATA(m_pwdata), .M_PRDATA(m_prdata), .M_PREADY(m_pready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_psel", {31'd0, m_psel}, 32'd0);
        chk("rst_pen", {31'd0, m_penable}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_paddr", {16'd0, m_paddr}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Zero-wait load
        req = 1'b1; we = 1'b0; addr = 16'h0010;
        step();
        chk("zw_c1_psel", {31'd0, m_psel}, 32'd1);
        chk("zw_c1_pen", {31'd0, m_penable}, 32'd0);
        chk("zw_c1_paddr", {16'd0, m_paddr}, 32'h0010);
        chk("zw_c1_busy", {31'd0, busy}, 32'd1);
        step();
        chk("zw_c2_pen", {31'd0, m_penable}, 32'd1);
        m_pready = 1'b1; m_prdata = 16'hBEEF;
        step();
        chk("zw_c3_ack", {31'd0, ack}, 32'd1);
        chk("zw_c3_rdata", {16'd0, rdata}, 32'hBEEF);
        chk("zw_c3_err", {31'd0, err}, 32'd0);
        chk("zw_c3_psel", {31'd0, m_psel}, 32'd0);
        req = 1'b0; m_pready = 1'b0; m_prdata = 16'h0000;
        step();
        chk("zw_c4_ack", {31'd0, ack}, 32'd0);

        // Store with 3 wait states
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h1234;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("ws_paddr", {16'd0, m_paddr}, 32'h0020);
            chk("ws_pwdata", {16'd0, m_pwdata}, 32'h1234);
            chk("ws_pwrite", {31'd0, m_pwrite}, 32'd1);
            chk("ws_noack", {31'd0, ack}, 32'd0);
            if (c == 5) m_pready = 1'b1;
        end
        step();
        chk("ws_c6_ack", {31'd0, ack}, 32'd1);
        chk("ws_c6_rdata", {16'd0, rdata}, 32'hBEEF);
        req = 1'b0; m_pready = 1'b0;
        step();

        // Request hygiene: addr changes mid-flight, req held through ack
        req = 1'b1; we = 1'b0; addr = 16'h0030;
        step();
        step();
        addr = 16'h0099;
        step();
        chk("hy_paddr", {16'd0, m_paddr}, 32'h0030);
        chk("hy_pen", {31'd0, m_penable}, 32'd1);
        m_pready = 1'b1; m_prdata = 16'h5A5A;
        step();
        chk("hy_ack", {31'd0, ack}, 32'd1);
        chk("hy_rdata", {16'd0, rdata}, 32'h5A5A);
        m_pready = 1'b0;
        step();
        chk("hy_nosetup", {31'd0, m_psel}, 32'd0);
        chk("hy_noack2", {31'd0, ack}, 32'd0);
        req = 1'b0;
        step();
        step();
        chk("hy_idle_psel", {31'd0, m_psel}, 32'd0);
        chk("hy_idle_busy", {31'd0, busy}, 32'd0);
        req = 1'b1; addr = 16'h0040;
        step();
        chk("hy_new_psel", {31'd0, m_psel}, 32'd1);
        chk("hy_new_paddr", {16'd0, m_paddr}, 32'h0040);
        step();
        m_pready = 1'b1; m_prdata = 16'h1111;
        step();
        chk("hy_new_ack", {31'd0, ack}, 32'd1);
        req = 1'b0; m_pready = 1'b0;
        step();

        // Back-to-back loads
        req = 1'b1; addr = 16'h0050;
        step();
        step();
        m_pready = 1'b1; m_prdata = 16'hA1A1;
        step();
        chk("bb_ack1", {31'd0, ack}, 32'd1);
        chk("bb_rdata1", {16'd0, rdata}, 32'hA1A1);
        m_pready = 1'b0; addr = 16'h0060;
        step();
        chk("bb_gap_psel", {31'd0, m_psel}, 32'd0);
        step();
        chk("bb_setup2", {31'd0, m_psel}, 32'd1);
        chk("bb_paddr2", {16'd0, m_paddr}, 32'h0060);
        step();
        m_pready = 1'b1; m_prdata = 16'hA2A2;
        chk("bb_noack_c6", {31'd0, ack}, 32'd0);
        step();
        chk("bb_ack2", {31'd0, ack}, 32'd1);
        chk("bb_rdata2", {16'd0, rdata}, 32'hA2A2);
        req = 1'b0; m_pready = 1'b0;
        step();

        // Async reset mid-ACCESS
        req = 1'b1; addr = 16'h0070;
        step();
        step();
        chk("ar_pen", {31'd0, m_penable}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_psel", {31'd0, m_psel}, 32'd0);
        chk("ar_pen0", {31'd0, m_penable}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_rdata", {16'd0, rdata}, 32'd0);
        req = 1'b0;
        step();
        chk("ar_noack", {31'd0, ack}, 32'd0);
        reset = 1'b1;
        step();
        req = 1'b1; we = 1'b1; addr = 16'h0080; wdata = 16'hCAFE;
        step();
        chk("ar_new_paddr", {16'd0, m_paddr}, 32'h0080);
        chk("ar_new_pwdata", {16'd0, m_pwdata}, 32'hCAFE);
        step();
        m_pready = 1'b1;
        step();
        chk("ar_new_ack", {31'd0, ack}, 32'd1);
        chk("ar_new_err", {31'd0, err}, 32'd0);
        chk("ar_new_rdata", {16'd0, rdata}, 32'd0);
        req = 1'b0; m_pready = 1'b0;
        step();

`ifdef APB_MASTER_TIMEOUT_EN
        // PREADY exactly at expiry: normal completion
        req = 1'b1; we = 1'b0; addr = 16'h0090;
        step();
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("tr_pen", {31'd0, m_penable}, 32'd1);
            if (c == 5) begin
                m_pready = 1'b1; m_prdata = 16'h7777;
            end
        end
        step();
        chk("tr_ack", {31'd0, ack}, 32'd1);
        chk("tr_err", {31'd0, err}, 32'd0);
        chk("tr_rdata", {16'd0, rdata}, 32'h7777);
        req = 1'b0; m_pready = 1'b0;
        step();

        // PREADY never arrives: abort after 4 ACCESS cycles
        req = 1'b1; addr = 16'h00A0;
        step();
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("to_pen", {31'd0, m_penable}, 32'd1);
            chk("to_noack", {31'd0, ack}, 32'd0);
        end
        step();
        chk("to_ack", {31'd0, ack}, 32'd1);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_rdata", {16'd0, rdata}, 32'd0);
        chk("to_psel", {31'd0, m_psel}, 32'd0);
        req = 1'b0;
        step();
        req = 1'b1; addr = 16'h00B0;
        step();
        chk("to_err_clr", {31'd0, err}, 32'd0);
        step();
        m_pready = 1'b1;
        step();
        req = 1'b0; m_pready = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
